// File: rtl/riscv_pkg.sv
// Shared RV32M/RV64M definitions: M-extension operation encoding and the
// state encoding used by the multiply/divide execution unit.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Values match funct3 of OP instructions with funct7 = FUNCT7_MULDIV.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_oper_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ITER = 2'd1,
    DONE     = 2'd2
  } muldiv_state_t;

  function automatic logic is_div_oper(input muldiv_oper_t oper);
    return oper[2];
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes: one quotient bit per cycle,
// with next-state values exposed so the caller can capture the final step.
module div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] quotient_next,
  output logic [XLEN-1:0] remainder_next
);

  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic [CW-1:0]   cnt_q;
  logic            run_q;
  logic [XLEN:0]   trial;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dsr_q};
    if (trial[XLEN]) begin
      remainder_next = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quotient_next  = {quo_q[XLEN-2:0], 1'b0};
    end else begin
      remainder_next = trial[XLEN-1:0];
      quotient_next  = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  assign last = run_q && (cnt_q == '0);

  // NOTE: datapath registers are reset too, so no X ever reaches the subtractor or result mux.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (flush) begin
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= CW'(XLEN - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= remainder_next;
      quo_q <= quotient_next;
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide unit: single-cycle multiply, iterative divide,
// valid/ready handshake on both sides, kill flush and pass-through tag.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       oper_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  muldiv_state_t    state_q;
  muldiv_oper_t     oper;
  logic             accept;
  logic             out_valid_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             rem_sel_q;

  assign oper   = muldiv_oper_t'(oper_i);
  assign accept = in_valid_i && (state_q == IDLE) && !kill_i;

  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] a_wide;
  logic [2*XLEN-1:0] b_wide;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   mul_result;

  // The low 2*XLEN bits of the product of sign/zero-extended operands are exact.
  always_comb begin
    a_signed   = (oper != MULHU);
    b_signed   = (oper == MUL) || (oper == MULH);
    a_wide     = {{XLEN{a_signed & rs1_i[XLEN-1]}}, rs1_i};
    b_wide     = {{XLEN{b_signed & rs2_i[XLEN-1]}}, rs2_i};
    product    = a_wide * b_wide;
    mul_result = (oper == MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  logic            div_signed;
  logic            rem_sel;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] abs1;
  logic [XLEN-1:0] abs2;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] special_result;

  always_comb begin
    div_signed     = !oper_i[0];
    rem_sel        = oper_i[1];
    neg1           = div_signed & rs1_i[XLEN-1];
    neg2           = div_signed & rs2_i[XLEN-1];
    abs1           = neg1 ? -rs1_i : rs1_i;
    abs2           = neg2 ? -rs2_i : rs2_i;
    div_zero       = (rs2_i == '0);
    div_ovf        = div_signed && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
    special_result = div_zero ? (rem_sel ? rs1_i : '1) : (rem_sel ? '0 : rs1_i);
  end

  logic            div_start;
  logic            div_last;
  logic [XLEN-1:0] quotient_next;
  logic [XLEN-1:0] remainder_next;
  logic [XLEN-1:0] div_result;

  assign div_start = accept && is_div_oper(oper) && !div_zero && !div_ovf;

  div_iter #(.XLEN(XLEN)) u_div_iter (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .start          (div_start),
    .flush          (kill_i),
    .dividend       (abs1),
    .divisor        (abs2),
    .last           (div_last),
    .quotient_next  (quotient_next),
    .remainder_next (remainder_next)
  );

  assign div_result = rem_sel_q ? (r_neg_q ? -remainder_next : remainder_next)
                                : (q_neg_q ? -quotient_next  : quotient_next);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rem_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q     <= tag_i;
            q_neg_q   <= neg1 ^ neg2;
            r_neg_q   <= neg1;
            rem_sel_q <= rem_sel;
            if (!is_div_oper(oper)) begin
              result_q    <= mul_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (div_zero || div_ovf) begin
              result_q    <= special_result;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= DIV_ITER;
            end
          end
        end
        DIV_ITER: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else if (div_last) begin
            result_q    <= div_result;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (kill_i || out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign tag_o       = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against an arithmetic reference model, and kill/hold/reset sequences.
module tb_muldiv_unit;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       oper;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] tag;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .oper_i      (oper),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .tag_i       (tag),
    .kill_i      (kill),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .tag_o       (tag_out),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic with the RISC-V special cases.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (muldiv_oper_t'(op))
      MUL:    begin p = sa * sb; return p[31:0];  end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  begin p = ua * ub; return p[63:32]; end
      DIV:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
      REM:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!op[2] || b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Called and returning at a falling edge; issues one op and retires it.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp_res,
                       input int exp_lat);
    int  lat;
    bit  ready_low;
    check({name, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    oper     = op;
    rs1      = a;
    rs2      = b;
    tag      = t;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    lat       = 1;
    ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready) ready_low = 1'b0;
    check({name, ".latency"}, lat, exp_lat);
    check({name, ".result"}, result, exp_res);
    check({name, ".tag"}, tag_out, t);
    check({name, ".ready_low_while_busy"}, ready_low, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ".idle_after_ack"}, {in_ready, busy, out_valid}, 3'b100);
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] t;
    logic [31:0] res;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;
    bit  stable;

    vecs[0]  = '{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1};
    vecs[1]  = '{"mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 1};
    vecs[2]  = '{"mulhu_ones",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1};
    vecs[3]  = '{"mulhsu_ones",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 1};
    vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    vecs[6]  = '{"divu_by_zero",  3'd5, 32'd5,          32'd0,         5'd9,  32'hFFFF_FFFF, 1};
    vecs[7]  = '{"remu_by_zero",  3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1};
    vecs[8]  = '{"div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
    vecs[9]  = '{"rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1};
    vecs[10] = '{"rem_m7_by_0",   3'd6, 32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9, 1};
    vecs[11] = '{"remu_big_10",   3'd7, 32'hFFFF_FFFF, 32'd10,        5'd14, 32'd5,         33};
    vecs[12] = '{"div_7_m2",      3'd4, 32'd7,          32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, 33};
    vecs[13] = '{"rem_7_m2",      3'd6, 32'd7,          32'hFFFF_FFFE, 5'd31, 32'd1,         33};

    rstn      = 1'b0;
    in_valid  = 1'b0;
    oper      = '0;
    rs1       = '0;
    rs2       = '0;
    tag       = '0;
    kill      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset.outputs", {out_valid, in_ready, busy, result, tag_out}, {3'b010, 32'd0, 5'd0});
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].res, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [4:0]  t;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      t  = 5'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -$urandom_range(1, 15);
        default: ;
      endcase
      do_op($sformatf("rand%0d", i), op, a, b, t, ref_result(op, a, b), ref_latency(op, a, b));
    end

    // Kill during the divide: no result, unit free on the next cycle.
    in_valid = 1'b1; oper = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; tag = 5'd17;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seen     = 1'b0;
    for (int k = 1; k < 10; k++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill.no_valid_before", seen, 0);
    check("kill.idle_next", {in_ready, busy, out_valid}, 3'b100);
    do_op("kill.mul_after", 3'd0, 32'd2, 32'd3, 5'd18, 32'd6, 1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("kill.no_stale_result", seen, 0);

    // Kill in IDLE blocks acceptance of a simultaneous request.
    in_valid = 1'b1; kill = 1'b1; oper = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("idle_kill.not_accepted", {in_ready, busy, out_valid}, 3'b100);

    // Result held while the consumer stalls.
    in_valid = 1'b1; oper = 3'd5; rs1 = 32'd100; rs2 = 32'd7; tag = 5'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("hold.latency", cnt, 33);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || result !== 32'd14 || tag_out !== 5'd9) stable = 1'b0;
      @(negedge clk);
    end
    check("hold.stable", stable, 1);
    check("hold.result", result, 32'd14);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold.idle_after_ack", {in_ready, busy, out_valid}, 3'b100);

    // Asynchronous reset mid-divide.
    in_valid = 1'b1; oper = 3'd4; rs1 = 32'd12345; rs2 = 32'd7; tag = 5'd22;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst.busy_before", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst.immediate", {out_valid, in_ready, busy, result, tag_out}, {3'b010, 32'd0, 5'd0});
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen |= out_valid;
      @(negedge clk);
    end
    check("rst.discarded", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised RV32M/RV64M multiply/divide execution unit that sits beside the ALU in the execute stage. It accepts one operation per request through a valid/ready handshake. Multiplies complete in a single registered cycle; divides and remainders use an iterative radix-2 restoring divider. A kill input flushes an in-flight operation, and an opaque destination tag travels alongside the operation to the writeback stage.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64).
TAG_W, 5, width of the pass-through tag (rd index).

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
in_valid_i  in  1  request valid
in_ready_o  out  1  unit can accept a request
oper_i  in  3  muldiv_oper_t, the funct3 of the OP instruction with funct7=0000001
rs1_i  in  XLEN  operand 1
rs2_i  in  XLEN  operand 2
tag_i  in  TAG_W  tag captured with the request
kill_i  in  1  flush the in-flight operation
out_valid_o  out  1  result valid
out_ready_i  in  1  consumer accepts the result
result_o  out  XLEN  result
tag_o  out  TAG_W  tag of the result
busy_o  out  1  state != IDLE

Behaviour:
- Reset: the asynchronous active-low reset takes effect immediately, whether or not an operation is in flight.
  - Reset values: state=IDLE, out_valid_o=0, result_o=0, tag_o=0, busy_o=0, in_ready_o=1.
  - An in-flight operation is discarded with no result produced.
- States: IDLE, DIV_ITER, DONE.
- in_ready_o=1 only in IDLE. A request is accepted when in_valid_i && in_ready_o && !kill_i.
  - If kill_i is high in the same cycle, the request is not accepted.
- Request accepted at cycle T, MUL/MULH/MULHSU/MULHU:
  - A 2*XLEN product is formed from sign/zero-extended operands:
    - MUL: signed x signed
    - MULH: signed x signed
    - MULHSU: signed x unsigned
    - MULHU: unsigned x unsigned
  - Result is the low half for MUL and the high half for the others.
  - Registered into DONE; out_valid_o=1 at T+1.
- Request accepted at cycle T, DIV/DIVU/REM/REMU:
  - Signed variants take absolute values and record the quotient sign (rs1 sign XOR rs2 sign) and the remainder sign (rs1 sign).
  - Special cases, resolved at acceptance; DONE at T+1:
    - Divisor == 0: quotient = all ones; remainder = rs1_i.
    - Signed overflow (rs1 = most-negative, rs2 = all ones): quotient = rs1_i; remainder = 0.
  - Otherwise enter DIV_ITER. A counter runs XLEN-1 down to 0, one quotient bit per cycle.
  - On the iteration that ends with count == 0: apply sign correction, select quotient or remainder, and enter DONE.
  - out_valid_o=1 at T+XLEN+1 (T+33 for XLEN=32).
- DONE:
  - result_o and tag_o are held stable while out_valid_o && !out_ready_i.
  - On out_ready_i: next cycle state=IDLE and out_valid_o=0.
  - No back-to-back acceptance from DONE.
- kill_i in DIV_ITER or DONE: next cycle state=IDLE, out_valid_o=0. kill_i has priority over out_ready_i. kill_i in IDLE has no effect.
- tag_o always equals the tag_i captured at acceptance.
- Unsigned/signed arithmetic is done at width XLEN+1 inside the divider. No X propagation from unused operand bits.

Decomposition:
- Added to riscv_pkg:
  - muldiv_oper_t enum: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - Constant FUNCT7_MULDIV = 7'b0000001.
- Sub-module: div_iter, holding the restoring divider datapath: remainder/quotient shift registers, counter, start/done.
- The FSM, the multiplier and the sign handling stay in muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, tag=3 at T -> out_valid at T+1, result 0xFFFFFFEB, tag_o=3.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at T+33; REM same operands -> 0xFFFFFFFF; in_ready_o=0 during T+1..T+33.
- DIVU 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0 at T+1.
- DIV accepted at T, kill_i at T+10 -> out_valid_o never rises, in_ready_o=1 at T+11; new MUL 2x3 at T+11 -> 6 at T+12.
- out_ready_i held low 5 cycles after a DIVU 100/7 -> result 14 and tag stable throughout; IDLE one cycle after out_ready_i=1. Assert rstn_i mid-DIV -> all outputs at reset values immediately.
